afu_rfifo_rd_drain: RTL

Single-clock read-side drain stage for the AFU response FIFO. It pops words from the FIFO read port and buffers them in a 3-entry skid buffer. It splits each word into data, tag and last fields and presents them on a valid/ready stream to the downstream response consumer. It also tracks packet framing and, optionally, beat and packet statistics.

---
 rtl/afu_rfifo_rd_drain.sv | 76 +++++++
 1 files changed

// File: rtl/afu_rfifo_rd_drain.sv
// afu_rfifo_rd_drain: AFU response FIFO read drain with 3-entry skid buffer and framing FSM.
// Define AFU_RFIFO_RD_STATS_EN to build the saturating beat/packet counters.
module afu_rfifo_rd_drain #(
   parameter int WIDTH = 521,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              aclr,
   input  logic [WIDTH-1:0]  fifo_q,
   input  logic              fifo_rdempty,
   output logic              fifo_rdreq,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-10:0] out_data,
   output logic [7:0]        out_tag,
   output logic              out_last,
   output logic              busy,
   output logic [CNT_W-1:0]  beat_cnt,
   output logic [CNT_W-1:0]  pkt_cnt
);
   typedef enum logic {IDLE, IN_PKT} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] mem [3];
   logic [WIDTH-1:0] head;
   logic [1:0] rd_ptr, wr_ptr, occ;
   logic inflight, pop;

   // Credit check counts the in-flight word so the buffer can never overflow
   assign fifo_rdreq = !aclr && !fifo_rdempty && ({1'b0, occ} + {2'b0, inflight} < 3'd3);
   assign out_valid = occ != 2'd0;
   assign pop = out_valid && out_ready;
   assign head = out_valid ? mem[rd_ptr] : '0;
   assign out_last = head[WIDTH-1];
   assign out_tag = head[WIDTH-2:WIDTH-9];
   assign out_data = head[WIDTH-10:0];

   always_ff @(posedge clk)
      if (inflight) mem[wr_ptr] <= fifo_q;

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         rd_ptr <= 2'd0;
         wr_ptr <= 2'd0;
         occ <= 2'd0;
         inflight <= 1'b0;
         state <= IDLE;
      end else begin
         inflight <= fifo_rdreq;
         if (inflight) wr_ptr <= wr_ptr == 2'd2 ? 2'd0 : wr_ptr + 2'd1;
         if (pop) rd_ptr <= rd_ptr == 2'd2 ? 2'd0 : rd_ptr + 2'd1;
         if (inflight != pop) occ <= inflight ? occ + 2'd1 : occ - 2'd1;
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (pop) state_nxt = out_last ? IDLE : IN_PKT;
      busy = out_valid || inflight || state == IN_PKT;
   end

`ifdef AFU_RFIFO_RD_STATS_EN
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         beat_cnt <= '0;
         pkt_cnt <= '0;
      end else if (pop) begin
         if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
         if (out_last && pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
      end
   end
`else
   assign beat_cnt = '0;
   assign pkt_cnt = '0;
`endif
endmodule
